// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between the
// instruction-fetch port (I) and the load/store port (D); one transaction in flight.
module mem_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int MEM_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [1:0]        estado
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic              gnt_i_s;
   logic              gnt_d_s;
   logic              last_s;
   logic              owner_r;
   logic              last_gnt_r;
   logic              we_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              i_done_r;
   logic              d_done_r;
   logic [DATA_W-1:0] i_rdata_r;
   logic [DATA_W-1:0] d_rdata_r;
   logic              mem_en_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;

   // Next-state and grant decision; on a tie the port that did not win last time wins.
   always_comb begin
      state_s = state_r;
      gnt_i_s = 1'b0;
      gnt_d_s = 1'b0;
      last_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (i_req && (!d_req || (last_gnt_r == OWN_D))) begin
               gnt_i_s = 1'b1;
               state_s = ACCESS;
            end else if (d_req) begin
               gnt_d_s = 1'b1;
               state_s = ACCESS;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (cnt_r == CNT_ZERO) begin
               last_s  = 1'b1;
               state_s = RESP;
            end else begin
               state_s = ACCESS;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Request latching, memory strobe, latency counter, read-data capture and done pulses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         owner_r     <= OWN_I;
         last_gnt_r  <= OWN_D;
         we_r        <= 1'b0;
         cnt_r       <= CNT_ZERO;
         i_done_r    <= 1'b0;
         d_done_r    <= 1'b0;
         i_rdata_r   <= {DATA_W{1'b0}};
         d_rdata_r   <= {DATA_W{1'b0}};
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
      end else begin
         i_done_r <= last_s && (owner_r == OWN_I);
         d_done_r <= last_s && (owner_r == OWN_D);
         if (gnt_i_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= i_addr;
            mem_wdata_r <= {DATA_W{1'b0}};
            owner_r     <= OWN_I;
            last_gnt_r  <= OWN_I;
            we_r        <= 1'b0;
            cnt_r       <= CNT_LOAD;
         end else if (gnt_d_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= d_we;
            mem_addr_r  <= d_addr;
            mem_wdata_r <= d_wdata;
            owner_r     <= OWN_D;
            last_gnt_r  <= OWN_D;
            we_r        <= d_we;
            cnt_r       <= CNT_LOAD;
         end else begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            if ((state_r == ACCESS) && (cnt_r != CNT_ZERO)) begin
               cnt_r <= cnt_r - CNT_ONE;
            end
         end
         // Stores leave both read-data registers untouched.
         if (last_s && !we_r) begin
            if (owner_r == OWN_D) begin
               d_rdata_r <= mem_rdata;
            end else begin
               i_rdata_r <= mem_rdata;
            end
         end
      end
   end

   assign i_done    = i_done_r;
   assign d_done    = d_done_r;
   assign i_rdata   = i_rdata_r;
   assign d_rdata   = d_rdata_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign busy      = (state_r != IDLE);
   assign estado    = state_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=1 instance with a small memory model and a
// MEM_LAT=3 instance whose read data changes every cycle to pin down the capture cycle.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we;
   logic [63:0] i_addr, d_addr, d_wdata;
   logic        i_done, d_done, mem_en, mem_we, busy;
   logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  estado;

   logic        i_req3;
   logic [63:0] i_addr3;
   logic        i_done3, d_done3, mem_en3, mem_we3, busy3;
   logic [63:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
   logic [1:0]  estado3;

   logic [63:0] mem [0:63];
   logic [63:0] mem_q;
   logic        mem_rvalid;
   logic [63:0] cyc = 64'd0;

   logic [63:0] en_log[$];
   bit          done_log[$];
   int          viol = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clock = ~clock;

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .estado(estado)
   );

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) dut3 (
      .clock(clock), .reset(reset),
      .i_req(i_req3), .i_addr(i_addr3), .i_done(i_done3), .i_rdata(i_rdata3),
      .d_req(1'b0), .d_we(1'b0), .d_addr(64'd0), .d_wdata(64'd0),
      .d_done(d_done3), .d_rdata(d_rdata3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_rdata(mem_rdata3), .busy(busy3), .estado(estado3)
   );

   // One-cycle-latency memory; read data is a poison value outside its valid cycle.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 64; k++) mem[k] <= 64'd0;
         mem[8]     <= 64'hDEAD;
         mem[32]    <= 64'h1234;
         mem_q      <= 64'd0;
         mem_rvalid <= 1'b0;
      end else begin
         mem_rvalid <= mem_en && !mem_we;
         if (mem_en) begin
            if (mem_we) mem[mem_addr[8:3]] <= mem_wdata;
            mem_q <= mem[mem_addr[8:3]];
         end
      end
   end
   assign mem_rdata  = mem_rvalid ? mem_q : 64'hBAD0_BAD0_BAD0_BAD0;

   always @(posedge clock) cyc <= cyc + 64'd1;
   assign mem_rdata3 = 64'hC000 + cyc;

   // Event log plus protocol watch on both instances.
   always @(negedge clock) begin
      if (mem_en) en_log.push_back(mem_addr);
      if (i_done) done_log.push_back(1'b0);
      if (d_done) done_log.push_back(1'b1);
      viol <= viol + int'(i_done && d_done) + int'(mem_en && (estado != 2'd1))
                   + int'(mem_en3 && (estado3 != 2'd1)) + int'(d_done3);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int          ndone;
      int          k_end;
      int          acc;
      int          n3;
      bit          seen;
      logic [63:0] c0;

      reset = 1'b0;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = 64'd0; d_addr = 64'd0; d_wdata = 64'd0;
      i_req3 = 1'b0; i_addr3 = 64'd0;
      repeat (3) step();
      check("rst_estado", {62'd0, estado}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_mem_en", {63'd0, mem_en}, 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_done", {62'd0, i_done, d_done}, 64'd0);
      check("rst_rdata", i_rdata | d_rdata, 64'd0);
      reset = 1'b1;
      step();

      // 1: single fetch
      en_log.delete(); done_log.delete();
      i_addr = 64'h40; i_req = 1'b1;
      step();
      check("t1_en_c1", {63'd0, mem_en}, 64'd1);
      check("t1_addr_c1", mem_addr, 64'h40);
      check("t1_we_c1", {63'd0, mem_we}, 64'd0);
      check("t1_busy_c1", {63'd0, busy}, 64'd1);
      step();
      check("t1_en_c2", {63'd0, mem_en}, 64'd0);
      check("t1_done_c2", {63'd0, i_done}, 64'd0);
      step();
      check("t1_idone_c3", {63'd0, i_done}, 64'd1);
      check("t1_rdata", i_rdata, 64'hDEAD);
      check("t1_estado_c3", {62'd0, estado}, 64'd2);
      i_req = 1'b0;
      step();
      check("t1_idone_c4", {63'd0, i_done}, 64'd0);
      check("t1_idle_c4", {62'd0, estado}, 64'd0);
      check("t1_ndone", 64'(done_log.size()), 64'd1);
      check("t1_no_ddone", 64'(done_log.sum() with (int'(item))), 64'd0);

      // 2: store then load of the same address
      d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'h55; d_req = 1'b1;
      step();
      check("t2_en", {62'd0, mem_en, mem_we}, 64'd3);
      check("t2_wdata", mem_wdata, 64'h55);
      check("t2_addr", mem_addr, 64'h100);
      step();
      check("t2_en_c2", {63'd0, mem_en}, 64'd0);
      step();
      check("t2_ddone", {63'd0, d_done}, 64'd1);
      check("t2_store_rdata", d_rdata, 64'd0);
      d_req = 1'b0;
      step();
      d_we = 1'b0; d_wdata = 64'd0; d_req = 1'b1;
      repeat (3) step();
      check("t2_load_done", {63'd0, d_done}, 64'd1);
      check("t2_load_rdata", d_rdata, 64'h55);
      check("t2_i_rdata_kept", i_rdata, 64'hDEAD);
      d_req = 1'b0;
      step();
      check("t2_en_count", 64'(en_log.size()), 64'd3);

      // 3: simultaneous requests after reset, I first then D without reasserting
      reset = 1'b0;
      step();
      reset = 1'b1;
      en_log.delete(); done_log.delete();
      i_addr = 64'h40; d_addr = 64'h100; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      seen = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (i_done) begin
            check("t3_idone_cyc", 64'(k), 64'd3);
            i_req = 1'b0;
         end
         if (d_done) begin
            check("t3_ddone_cyc", 64'(k), 64'd7);
            check("t3_d_rdata", d_rdata, 64'h1234);
            d_req = 1'b0;
            seen = 1'b1;
            break;
         end
      end
      check("t3_d_served", {63'd0, seen}, 64'd1);
      i_req = 1'b0; d_req = 1'b0;
      step();
      check("t3_en_count", 64'(en_log.size()), 64'd2);
      check("t3_order0", (en_log.size() > 0) ? en_log[0] : 64'hX, 64'h40);
      check("t3_order1", (en_log.size() > 1) ? en_log[1] : 64'hX, 64'h100);

      // 4: both held for six transactions, grants alternate starting with I
      en_log.delete(); done_log.delete();
      i_req = 1'b1; d_req = 1'b1;
      ndone = 0; k_end = 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (i_done || d_done) ndone++;
         if (ndone == 6) begin
            k_end = k;
            break;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      check("t4_ndone", 64'(ndone), 64'd6);
      check("t4_last_cyc", 64'(k_end), 64'd23);
      step(); step();
      check("t4_en_count", 64'(en_log.size()), 64'd6);
      check("t4_done_count", 64'(done_log.size()), 64'd6);
      for (int j = 0; j < 6; j++) begin
         check($sformatf("t4_addr%0d", j), (en_log.size() > j) ? en_log[j] : 64'hX,
               (j % 2 == 1) ? 64'h100 : 64'h40);
         check($sformatf("t4_done%0d", j), (done_log.size() > j) ? 64'(done_log[j]) : 64'hX,
               64'(j % 2));
      end

      // 5: reset during ACCESS aborts; pending request re-granted from scratch
      i_addr = 64'h40; i_req = 1'b1;
      step();
      check("t5_access", {62'd0, estado}, 64'd1);
      reset = 1'b0;
      #1;
      check("t5_estado", {62'd0, estado}, 64'd0);
      check("t5_busy", {63'd0, busy}, 64'd0);
      check("t5_mem", {63'd0, mem_en} | mem_addr, 64'd0);
      check("t5_rdata", i_rdata | d_rdata, 64'd0);
      done_log.delete();
      step(); step();
      reset = 1'b1;
      step();
      check("t5_regrant_en", {63'd0, mem_en}, 64'd1);
      check("t5_regrant_addr", mem_addr, 64'h40);
      step(); step();
      check("t5_idone", {63'd0, i_done}, 64'd1);
      check("t5_i_rdata", i_rdata, 64'hDEAD);
      check("t5_no_abort_done", 64'(done_log.size()), 64'd0);
      i_req = 1'b0;
      step();

      // 6: MEM_LAT=3 fetch
      i_addr3 = 64'h80; i_req3 = 1'b1;
      c0 = cyc;
      acc = 0; n3 = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (estado3 == 2'd1) acc++;
         if (k == 1) check("t6_en_c1", {63'd0, mem_en3}, 64'd1);
         if (k == 2) check("t6_en_c2", {63'd0, mem_en3}, 64'd0);
         if (i_done3) begin
            n3++;
            check("t6_idone_cyc", 64'(k), 64'd5);
            check("t6_rdata", i_rdata3, 64'hC000 + c0 + 64'd4);
            i_req3 = 1'b0;
         end
      end
      check("t6_access_len", 64'(acc), 64'd4);
      check("t6_ndone", 64'(n3), 64'd1);
      check("t6_mem_regs", mem_addr3, 64'h80);
      check("t6_wr_side", {63'd0, mem_we3} | mem_wdata3 | d_rdata3, 64'd0);
      check("t6_idle", {63'd0, busy3}, 64'd0);

      check("protocol_viol", 64'(viol), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
